// File: rtl/playback_timer.sv
// BCD mm:ss playback timer: counts up or down on a 1 Hz tick, saturates at its limits, supports loading.
// Optional fast seek (one step per clk) is compiled in when PLAYBACK_TIMER_SEEK_EN is defined.
module playback_timer #(
  parameter int MIN_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    down,
  input  logic                    load,
  input  logic [4*MIN_DIGITS+6:0] load_time,
  input  logic                    seek_valid,
  input  logic [5:0]              seek_sec,
  output logic [3:0]              seconds0,
  output logic [2:0]              seconds1,
  output logic [4*MIN_DIGITS-1:0] minutes,
  output logic                    seek_busy,
  output logic                    done
);
  localparam int MW = 4*MIN_DIGITS;

  logic [3:0]          s0_reg, s0_step, s0_load;
  logic [2:0]          s1_reg, s1_step, s1_load;
  logic [MW-1:0]       min_reg, min_step, min_load;
  logic                done_reg;
  logic                s0_wrap;
  logic [MIN_DIGITS:0] carry;
  logic                limit, land_zero, step_done, step_en;
  logic                busy, seek_start, seek_step, pend_step;

  // carry[i] is the carry/borrow into minute digit i; carry[MIN_DIGITS] means we sit on the limit.
  assign s0_wrap  = down ? (s0_reg == 4'd0) : (s0_reg == 4'd9);
  assign carry[0] = s0_wrap && (down ? (s1_reg == 3'd0) : (s1_reg == 3'd5));
  assign s0_step  = down ? (s0_wrap ? 4'd9 : s0_reg - 4'd1)
                         : (s0_wrap ? 4'd0 : s0_reg + 4'd1);
  assign s1_step  = !s0_wrap ? s1_reg
                  : down     ? ((s1_reg == 3'd0) ? 3'd5 : s1_reg - 3'd1)
                             : ((s1_reg == 3'd5) ? 3'd0 : s1_reg + 3'd1);
  assign s0_load  = (load_time[3:0] > 4'd9) ? 4'd9 : load_time[3:0];
  assign s1_load  = (load_time[6:4] > 3'd5) ? 3'd5 : load_time[6:4];

  for (genvar gi = 0; gi < MIN_DIGITS; gi++) begin : g_min
    logic [3:0] d, ld;
    assign d  = min_reg[4*gi +: 4];
    assign ld = load_time[7+4*gi +: 4];
    assign min_step[4*gi +: 4] = !carry[gi] ? d
                               : down       ? ((d == 4'd0) ? 4'd9 : d - 4'd1)
                                            : ((d == 4'd9) ? 4'd0 : d + 4'd1);
    assign carry[gi+1] = carry[gi] && (down ? (d == 4'd0) : (d == 4'd9));
    assign min_load[4*gi +: 4] = (ld > 4'd9) ? 4'd9 : ld;
  end

  // Stepping from a limit holds the value; landing on zero while counting down also finishes.
  assign limit     = carry[MIN_DIGITS];
  assign land_zero = down && (s0_step == 4'd0) && (s1_step == 3'd0) && (min_step == '0);
  assign step_done = limit || land_zero;
  assign step_en   = !load && !seek_start &&
                     (seek_step || pend_step || (tick && run && !done_reg && !busy));

`ifdef PLAYBACK_TIMER_SEEK_EN
  logic       busy_reg, pending_reg;
  logic [5:0] r_reg, seek_r;

  assign seek_r     = (seek_sec > 6'd59) ? 6'd59 : seek_sec;
  assign busy       = busy_reg;
  assign seek_start = seek_valid && !busy_reg;
  assign seek_step  = busy_reg;
  assign pend_step  = pending_reg && !busy_reg && !done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg    <= 1'b0;
      pending_reg <= 1'b0;
      r_reg       <= '0;
    end else if (load) begin
      busy_reg    <= 1'b0;
      pending_reg <= 1'b0;
      r_reg       <= '0;
    end else if (seek_start) begin
      r_reg    <= seek_r;
      busy_reg <= (seek_r != 6'd0);
    end else if (busy_reg) begin
      pending_reg <= pending_reg || (tick && run);
      // Hitting a limit abandons whatever distance is left.
      if (step_done || r_reg == 6'd1) begin
        busy_reg <= 1'b0;
        r_reg    <= '0;
      end else begin
        r_reg <= r_reg - 6'd1;
      end
    end else if (pending_reg) begin
      pending_reg <= 1'b0;
    end
  end
`else
  logic unused_seek;
  assign unused_seek = ^{seek_valid, seek_sec};
  assign busy        = 1'b0;
  assign seek_start  = 1'b0;
  assign seek_step   = 1'b0;
  assign pend_step   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_reg   <= '0;
      s1_reg   <= '0;
      min_reg  <= '0;
      done_reg <= 1'b0;
    end else if (load) begin
      s0_reg   <= s0_load;
      s1_reg   <= s1_load;
      min_reg  <= min_load;
      done_reg <= 1'b0;
    end else if (step_en) begin
      if (!limit) begin
        s0_reg  <= s0_step;
        s1_reg  <= s1_step;
        min_reg <= min_step;
      end
      done_reg <= done_reg || step_done;
    end
  end

  assign seconds0  = s0_reg;
  assign seconds1  = s1_reg;
  assign minutes   = min_reg;
  assign seek_busy = busy;
  assign done      = done_reg;
endmodule
